// File: rtl/periph_bus_arbiter_if.sv
// Peripheral bus bundle shared by the CPU data port (m0), the debug-port
// master (m1) and the single peripheral slave port (s_*).
// Modport "master" is the arbiter's view: it owns the peripheral bus and
// answers both requesters. Modport "slave" is the surrounding environment.
interface periph_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    // CPU data port (M0)
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [BE_W-1:0]   m0_be;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_err;

    // Debug-port master (M1)
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [BE_W-1:0]   m1_be;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_err;

    // Debug halt and ownership indication
    logic              dbg_lock;
    logic              grant_dbg;

    // Peripheral slave port
    logic              s_req;
    logic              s_we;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic [BE_W-1:0]   s_be;
    logic              s_ack;
    logic [DATA_W-1:0] s_rdata;

    modport master (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        output m1_ack, m1_rdata, m1_err,
        input  dbg_lock,
        output grant_dbg,
        output s_req, s_we, s_addr, s_wdata, s_be,
        input  s_ack, s_rdata
    );

    modport slave (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
        input  m1_ack, m1_rdata, m1_err,
        output dbg_lock,
        input  grant_dbg,
        input  s_req, s_we, s_addr, s_wdata, s_be,
        output s_ack, s_rdata
    );
endinterface

// File: rtl/periph_bus_arbiter.sv
// Two-master peripheral bus arbiter. One transaction at a time:
// IDLE samples requests, BUSY holds the slave request until ack or
// timeout, RESP returns a one-cycle ack to the owning master.
// The debug master wins unless it has starved the CPU for
// MAX_DBG_STREAK consecutive grants; dbg_lock blocks the CPU entirely.
module periph_bus_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_DBG_STREAK = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                  clk,
    input logic                  reset,
    periph_bus_arbiter_if.master bus
);
    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned STREAK_W = $clog2(MAX_DBG_STREAK + 1);
    localparam int unsigned TCNT_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DBG_STREAK);
    localparam logic [TCNT_W-1:0]   TCNT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t              state;
    logic                owner_m1;
    logic [STREAK_W-1:0] streak;
    logic [TCNT_W-1:0]   tcnt;

    logic                s_req_q;
    logic                s_we_q;
    logic [ADDR_W-1:0]   s_addr_q;
    logic [DATA_W-1:0]   s_wdata_q;
    logic [BE_W-1:0]     s_be_q;

    logic                m0_ack_q;
    logic [DATA_W-1:0]   m0_rdata_q;
    logic                m0_err_q;
    logic                m1_ack_q;
    logic [DATA_W-1:0]   m1_rdata_q;
    logic                m1_err_q;
    logic                grant_dbg_q;

    logic                sel_valid;
    logic                sel_m1;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic [BE_W-1:0]     sel_be;

    logic                busy_done;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;

    // Request selection in priority order: lock, starvation guard, debug, CPU
    always_comb begin
        sel_valid = 1'b0;
        sel_m1    = 1'b0;
        if (bus.dbg_lock) begin
            sel_valid = bus.m1_req;
            sel_m1    = 1'b1;
        end else if (bus.m1_req && bus.m0_req && (streak == STREAK_MAX)) begin
            sel_valid = 1'b1;
            sel_m1    = 1'b0;
        end else if (bus.m1_req) begin
            sel_valid = 1'b1;
            sel_m1    = 1'b1;
        end else if (bus.m0_req) begin
            sel_valid = 1'b1;
            sel_m1    = 1'b0;
        end
    end

    assign sel_we    = sel_m1 ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = sel_m1 ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = sel_m1 ? bus.m1_wdata : bus.m0_wdata;
    assign sel_be    = sel_m1 ? bus.m1_be    : bus.m0_be;

    // A slave ack on the expiry cycle takes precedence over the timeout
    assign busy_done = bus.s_ack || (tcnt == TCNT_LAST);
    assign rsp_data  = bus.s_ack ? bus.s_rdata : '0;
    assign rsp_err   = ~bus.s_ack;

    // Transaction sequencer with registered bus and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner_m1    <= 1'b0;
            streak      <= '0;
            tcnt        <= '0;
            s_req_q     <= 1'b0;
            s_we_q      <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_be_q      <= '0;
            m0_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m0_err_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m1_rdata_q  <= '0;
            m1_err_q    <= 1'b0;
            grant_dbg_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state       <= BUSY;
                        owner_m1    <= sel_m1;
                        grant_dbg_q <= sel_m1;
                        tcnt        <= '0;
                        s_req_q     <= 1'b1;
                        s_we_q      <= sel_we;
                        s_addr_q    <= sel_addr;
                        s_wdata_q   <= sel_wdata;
                        s_be_q      <= sel_be;
                        if (!sel_m1) begin
                            streak <= '0;
                        end else if (bus.m0_req && (streak != STREAK_MAX)) begin
                            streak <= streak + 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (busy_done) begin
                        state     <= RESP;
                        s_req_q   <= 1'b0;
                        s_we_q    <= 1'b0;
                        s_addr_q  <= '0;
                        s_wdata_q <= '0;
                        s_be_q    <= '0;
                        if (owner_m1) begin
                            m1_ack_q   <= 1'b1;
                            m1_rdata_q <= rsp_data;
                            m1_err_q   <= rsp_err;
                        end else begin
                            m0_ack_q   <= 1'b1;
                            m0_rdata_q <= rsp_data;
                            m0_err_q   <= rsp_err;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    m0_ack_q    <= 1'b0;
                    m0_rdata_q  <= '0;
                    m0_err_q    <= 1'b0;
                    m1_ack_q    <= 1'b0;
                    m1_rdata_q  <= '0;
                    m1_err_q    <= 1'b0;
                    grant_dbg_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s_req     = s_req_q;
    assign bus.s_we      = s_we_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wdata   = s_wdata_q;
    assign bus.s_be      = s_be_q;
    assign bus.m0_ack    = m0_ack_q;
    assign bus.m0_rdata  = m0_rdata_q;
    assign bus.m0_err    = m0_err_q;
    assign bus.m1_ack    = m1_ack_q;
    assign bus.m1_rdata  = m1_rdata_q;
    assign bus.m1_err    = m1_err_q;
    assign bus.grant_dbg = grant_dbg_q;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Bench for periph_bus_arbiter: directed scenarios plus randomized traffic,
// every cycle checked against a transaction-level model of the arbiter.
module tb_periph_bus_arbiter;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int          MAXSTR  = 4;
    localparam int          TIMEOUT = 16;

    logic clk;
    logic reset;

    periph_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    periph_bus_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_DBG_STREAK(MAXSTR),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // requester state
    logic        mreq[2];
    logic        mwe[2];
    logic [31:0] maddr[2];
    logic [31:0] mwdata[2];
    logic [3:0]  mbe[2];
    int          m_rate[2];
    bit          m_ack_prev[2];
    logic        lock_v;
    logic        rst_v;

    // slave state
    int          slave_mode;   // 0: fixed latency/rdata, 1: random
    int          slave_lat;
    logic [31:0] slave_rdata;
    int          sc;
    int          cur_lat;
    bit          prev_sreq;
    logic        s_ack_v;
    logic [31:0] s_rdata_v;

    // observations
    int          ack_cnt[2];
    int          dut_order[$];
    logic [31:0] last_rdata[2];
    logic        last_err[2];
    logic        last_grant;
    int          sreq_run;
    int          last_sreq_len;

    // transaction-level model
    bit          md_active;
    bit          md_resp;
    bit          md_owner;
    logic        md_we;
    logic [31:0] md_addr;
    logic [31:0] md_wdata;
    logic [3:0]  md_be;
    int          md_age;
    logic [31:0] md_rdata;
    bit          md_err;
    int          md_streak;
    int          grant_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        md_active = 0;
        md_resp   = 0;
        md_owner  = 0;
        md_age    = 0;
        md_streak = 0;
        md_err    = 0;
        md_rdata  = '0;
    endtask

    task automatic new_req(input int i);
        mwe[i]    = 1'($urandom_range(1));
        maddr[i]  = $urandom;
        mwdata[i] = $urandom;
        mbe[i]    = 4'($urandom_range(15));
        mreq[i]   = 1'b1;
    endtask

    task automatic issue(input int i, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        mwe[i]        = we;
        maddr[i]      = a;
        mwdata[i]     = wd;
        mbe[i]        = be;
        mreq[i]       = 1'b1;
        m_ack_prev[i] = 0;
    endtask

    function automatic int pick_lat();
        int r;
        if (slave_mode == 0) return slave_lat;
        r = int'($urandom_range(99));
        if (r < 10) return 1000;
        if (r < 15) return TIMEOUT - 1;
        return int'($urandom_range(4));
    endfunction

    // check outputs produced by the last rising edge, record events
    task automatic compare();
        bit e0, e1;
        e0 = md_resp && !md_owner;
        e1 = md_resp && md_owner;
        chk("s_req",     bus.s_req,     md_active);
        chk("s_we",      bus.s_we,      md_active ? md_we : 1'b0);
        chk("s_addr",    bus.s_addr,    md_active ? md_addr : 32'h0);
        chk("s_wdata",   bus.s_wdata,   md_active ? md_wdata : 32'h0);
        chk("s_be",      bus.s_be,      md_active ? md_be : 4'h0);
        chk("m0_ack",    bus.m0_ack,    e0);
        chk("m0_rdata",  bus.m0_rdata,  e0 ? md_rdata : 32'h0);
        chk("m0_err",    bus.m0_err,    e0 && md_err);
        chk("m1_ack",    bus.m1_ack,    e1);
        chk("m1_rdata",  bus.m1_rdata,  e1 ? md_rdata : 32'h0);
        chk("m1_err",    bus.m1_err,    e1 && md_err);
        chk("grant_dbg", bus.grant_dbg, (md_active || md_resp) && md_owner);

        if (bus.s_req === 1'b1) sreq_run++;
        else if (sreq_run > 0) begin
            last_sreq_len = sreq_run;
            sreq_run = 0;
        end
        if (bus.m0_ack === 1'b1) begin
            ack_cnt[0]++;
            dut_order.push_back(0);
            last_rdata[0] = bus.m0_rdata;
            last_err[0]   = bus.m0_err;
            last_grant    = bus.grant_dbg;
        end
        if (bus.m1_ack === 1'b1) begin
            ack_cnt[1]++;
            dut_order.push_back(1);
            last_rdata[1] = bus.m1_rdata;
            last_err[1]   = bus.m1_err;
            last_grant    = bus.grant_dbg;
        end
    endtask

    // decide and apply inputs for the coming rising edge
    task automatic drive();
        for (int i = 0; i < 2; i++) begin
            if (m_ack_prev[i]) mreq[i] = 1'b0;
            if (!mreq[i] && m_rate[i] > 0 && int'($urandom_range(99)) < m_rate[i]) new_req(i);
        end
        m_ack_prev[0] = (bus.m0_ack === 1'b1);
        m_ack_prev[1] = (bus.m1_ack === 1'b1);

        s_ack_v   = 1'b0;
        s_rdata_v = $urandom;
        if (bus.s_req === 1'b1) begin
            if (!prev_sreq) begin
                sc      = 0;
                cur_lat = pick_lat();
            end else begin
                sc++;
            end
            if (sc == cur_lat) begin
                s_ack_v   = 1'b1;
                s_rdata_v = (slave_mode == 0) ? slave_rdata : $urandom;
            end
        end
        prev_sreq = (bus.s_req === 1'b1);

        bus.m0_req   = mreq[0];
        bus.m0_we    = mwe[0];
        bus.m0_addr  = maddr[0];
        bus.m0_wdata = mwdata[0];
        bus.m0_be    = mbe[0];
        bus.m1_req   = mreq[1];
        bus.m1_we    = mwe[1];
        bus.m1_addr  = maddr[1];
        bus.m1_wdata = mwdata[1];
        bus.m1_be    = mbe[1];
        bus.dbg_lock = lock_v;
        bus.s_ack    = s_ack_v;
        bus.s_rdata  = s_rdata_v;
        reset        = rst_v;
    endtask

    // move the model across the coming rising edge using the applied inputs
    task automatic advance();
        int w;
        if (!reset) begin
            model_reset();
            return;
        end
        if (md_resp) begin
            md_resp = 0;
        end else if (md_active) begin
            if (bus.s_ack) begin
                md_rdata = bus.s_rdata; md_err = 0; md_active = 0; md_resp = 1;
            end else if (md_age == TIMEOUT - 1) begin
                md_rdata = '0; md_err = 1; md_active = 0; md_resp = 1;
            end else begin
                md_age++;
            end
        end else begin
            w = -1;
            if (lock_v) w = mreq[1] ? 1 : -1;
            else if (mreq[1] && mreq[0] && md_streak == MAXSTR) w = 0;
            else if (mreq[1]) w = 1;
            else if (mreq[0]) w = 0;
            if (w >= 0) begin
                md_active = 1;
                md_age    = 0;
                md_owner  = (w == 1);
                md_we     = mwe[w];
                md_addr   = maddr[w];
                md_wdata  = mwdata[w];
                md_be     = mbe[w];
                grant_log.push_back(w);
                if (w == 0) md_streak = 0;
                else if (mreq[0] && md_streak < MAXSTR) md_streak++;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        compare();
        drive();
        advance();
    endtask

    task automatic wait_ack(input int i, input int budget, input string name);
        int start;
        start = ack_cnt[i];
        for (int k = 0; k < budget && ack_cnt[i] == start; k++) step();
        chk({name, "_ack_seen"}, ack_cnt[i] - start, 1);
    endtask

    task automatic drain();
        m_rate[0] = 0;
        m_rate[1] = 0;
        for (int k = 0; k < 300; k++) begin
            if (!mreq[0] && !mreq[1] && !md_active && !md_resp) break;
            step();
        end
        chk("drain_idle", {mreq[0], mreq[1], md_active, md_resp}, 4'b0000);
        step();
    endtask

    int exp_order[11] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1};

    initial begin
        int s0, s1, ord, n;
        for (int i = 0; i < 2; i++) begin
            mreq[i] = 0; mwe[i] = 0; maddr[i] = '0; mwdata[i] = '0; mbe[i] = '0;
            m_rate[i] = 0; m_ack_prev[i] = 0; ack_cnt[i] = 0;
            last_rdata[i] = '0; last_err[i] = 0;
        end
        lock_v = 0; slave_mode = 0; slave_lat = 0; slave_rdata = '0;
        sc = 0; cur_lat = 0; prev_sreq = 0; sreq_run = 0; last_sreq_len = 0;
        last_grant = 0;
        model_reset();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_be = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_be = '0;
        bus.dbg_lock = 0; bus.s_ack = 0; bus.s_rdata = '0;
        reset = 1'b1;
        rst_v = 1'b0;
        #1 reset = 1'b0;

        // reset state
        repeat (3) step();
        chk("reset_s_req", bus.s_req, 0);
        chk("reset_m0_ack", bus.m0_ack, 0);
        chk("reset_grant", bus.grant_dbg, 0);
        rst_v = 1'b1;
        step();

        // single CPU read, slave acks 2 cycles after s_req
        slave_mode = 0; slave_lat = 2; slave_rdata = 32'hA5A5_0001;
        issue(0, 1'b0, 32'h0000_1004, 32'h0, 4'hF);
        s1 = ack_cnt[1];
        wait_ack(0, 20, "rd");
        chk("rd_rdata", last_rdata[0], 32'hA5A5_0001);
        chk("rd_err", last_err[0], 0);
        chk("rd_sreq_len", last_sreq_len, 3);
        chk("rd_no_m1_ack", ack_cnt[1] - s1, 0);
        chk("rd_model_owner", grant_log[grant_log.size() - 1], 0);
        drain();

        // both masters held, zero-wait slave: starvation guard ordering
        slave_lat = 0;
        dut_order.delete();
        grant_log.delete();
        m_rate[0] = 100; m_rate[1] = 100;
        for (int k = 0; k < 80 && dut_order.size() < 11; k++) step();
        chk("order_count", (dut_order.size() >= 11), 1);
        for (int k = 0; k < 11; k++) begin
            if (k < dut_order.size()) chk($sformatf("order_dut[%0d]", k), dut_order[k], exp_order[k]);
            if (k < grant_log.size()) chk($sformatf("order_model[%0d]", k), grant_log[k], exp_order[k]);
        end
        drain();

        // debug lock: M0 never granted, released lock grants M0 next
        lock_v = 1;
        s0 = ack_cnt[0]; s1 = ack_cnt[1];
        m_rate[0] = 100; m_rate[1] = 100;
        for (int k = 0; k < 100 && ack_cnt[1] - s1 < 10; k++) step();
        chk("lock_m1_acks", ack_cnt[1] - s1, 10);
        chk("lock_m0_acks", ack_cnt[0] - s0, 0);
        lock_v = 0;
        ord = dut_order.size();
        for (int k = 0; k < 20 && dut_order.size() == ord; k++) step();
        chk("unlock_next_owner", (dut_order.size() > ord) ? dut_order[ord] : 99, 0);
        drain();

        // timeout with a silent slave
        slave_lat = 1000;
        issue(0, 1'b0, 32'h0000_3000, 32'h0, 4'hF);
        wait_ack(0, 40, "to");
        chk("to_sreq_len", last_sreq_len, TIMEOUT);
        chk("to_err", last_err[0], 1);
        chk("to_rdata", last_rdata[0], 0);
        drain();

        // slave ack exactly on the expiry cycle wins
        slave_lat = TIMEOUT - 1; slave_rdata = 32'h1234_5678;
        issue(1, 1'b0, 32'h0000_3004, 32'h0, 4'hF);
        wait_ack(1, 40, "edge");
        chk("edge_sreq_len", last_sreq_len, TIMEOUT);
        chk("edge_err", last_err[1], 0);
        chk("edge_rdata", last_rdata[1], 32'h1234_5678);
        drain();

        // debug write: payload stable for every BUSY cycle, grant through RESP
        slave_lat = 3;
        issue(1, 1'b1, 32'h0000_2000, 32'h0000_00FF, 4'h1);
        s1 = ack_cnt[1];
        n = 0;
        for (int k = 0; k < 20 && ack_cnt[1] == s1; k++) begin
            step();
            if (bus.s_req === 1'b1) begin
                n++;
                chk("wr_s_we", bus.s_we, 1);
                chk("wr_s_addr", bus.s_addr, 32'h0000_2000);
                chk("wr_s_wdata", bus.s_wdata, 32'h0000_00FF);
                chk("wr_s_be", bus.s_be, 4'h1);
                chk("wr_grant_busy", bus.grant_dbg, 1);
            end
        end
        chk("wr_busy_cycles", n, 4);
        chk("wr_ack", ack_cnt[1] - s1, 1);
        chk("wr_grant_resp", last_grant, 1);
        drain();

        // asynchronous reset during BUSY aborts without an ack
        slave_lat = 1000;
        issue(0, 1'b0, 32'h0000_4000, 32'h0, 4'hF);
        s0 = ack_cnt[0];
        for (int k = 0; k < 10 && sreq_run < 3; k++) step();
        chk("rst_busy_reached", sreq_run >= 3, 1);
        #2;
        reset = 1'b0;
        rst_v = 1'b0;
        #1;
        chk("rst_async_s_req", bus.s_req, 0);
        chk("rst_async_m0_ack", bus.m0_ack, 0);
        chk("rst_async_m1_ack", bus.m1_ack, 0);
        chk("rst_async_grant", bus.grant_dbg, 0);
        model_reset();
        repeat (2) step();
        rst_v = 1'b1;
        slave_lat = 1; slave_rdata = 32'hCAFE_0002;
        step();
        chk("rst_no_ack", ack_cnt[0] - s0, 0);
        wait_ack(0, 20, "post_rst");
        chk("post_rst_rdata", last_rdata[0], 32'hCAFE_0002);
        chk("post_rst_err", last_err[0], 0);
        drain();

        // randomized traffic
        slave_mode = 1;
        m_rate[0] = 40; m_rate[1] = 40;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(99) < 2) lock_v = ~lock_v;
            step();
        end
        lock_v = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/periph_bus_arbiter.md
Name: periph_bus_arbiter

Overview:
- Shares the microcontroller's single peripheral bus (LED register, TIM1/TIM2, GPIO port A) between two masters: the CPU data port (M0) and the UART debug-port master (M1, present with FEATURE_DBG_PORT).
- Sequences one transaction at a time with a req/ack handshake.
- Debug master has priority, limited by a starvation guard; a timeout terminates transactions the slave never acknowledges.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enables = DATA_W/8).
- MAX_DBG_STREAK, 4, consecutive M1 grants allowed while M0 waits.
- TIMEOUT_CYCLES, 16, BUSY cycles without slave ack before an error termination (>=2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- m0_req / m1_req  in  1  transaction request; held with payload until that master's ack.
- m0_we / m1_we  in  1  1 = write.
- m0_addr / m1_addr  in  ADDR_W  byte address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_be / m1_be  in  DATA_W/8  byte enables.
- m0_ack / m1_ack  out  1  one-cycle completion pulse.
- m0_rdata / m1_rdata  out  DATA_W  read data, valid while ack=1.
- m0_err / m1_err  out  1  timeout flag, valid while ack=1.
- dbg_lock  in  1  1 = M0 never granted (debug halt).
- s_req  out  1  slave request.
- s_we  out  1  slave write enable.
- s_addr  out  ADDR_W  slave address.
- s_wdata  out  DATA_W  slave write data.
- s_be  out  DATA_W/8  slave byte enables.
- s_ack  in  1  slave completion.
- s_rdata  in  DATA_W  slave read data, valid with s_ack.
- grant_dbg  out  1  1 while M1 owns the bus (BUSY/RESP).

Behaviour:
- Reset: state=IDLE; all outputs 0; streak counter 0; timeout counter 0.
- Reset asserted mid-transaction aborts it. No ack is ever issued for the aborted transfer.
- States:
  - IDLE: sample requests. If any master is selected, register owner and payload into the s_* registers, set s_req=1, go BUSY.
  - BUSY: s_req held at 1 with stable payload.
    - s_ack=1: capture s_rdata, s_req->0, go RESP with err=0.
    - Else count. When count reaches TIMEOUT_CYCLES-1 in this cycle: s_req->0, captured data=0, go RESP with err=1.
    - s_ack on the expiry cycle: ack wins, err=0.
  - RESP: owner's ack=1 for exactly one cycle with captured rdata/err; the other master's ack=0. Go IDLE.
- Latency:
  - Request sampled in IDLE at cycle N; s_req=1 from N+1.
  - Slave ack at cycle K gives master ack at K+1.
  - Zero-wait slave (ack in first BUSY cycle): 3 cycles per transaction.
  - Back-to-back transactions never overlap.
- Masters deassert req (or change payload) the cycle after their ack. The arbiter does not re-grant in RESP, so no stale double-grant is possible.
- Selection in IDLE (highest first):
  1. dbg_lock=1: M1 if m1_req, else nothing (M0 stalls).
  2. m1_req && m0_req && streak==MAX_DBG_STREAK: M0.
  3. m1_req: M1.
  4. m0_req: M0.
- Streak counter:
  - +1 on each M1 grant made while m0_req=1 (saturates at MAX_DBG_STREAK).
  - Cleared on any M0 grant.
  - Unchanged on M1 grants with m0_req=0.
- dbg_lock changes only take effect at IDLE sampling; an in-flight M0 transaction completes normally.
- m*_rdata and m*_err are 0 whenever the corresponding ack=0.
- s_we, s_addr, s_wdata and s_be are zero in IDLE and RESP.
- grant_dbg=1 from the first BUSY cycle of an M1 grant through its RESP cycle.

Test Plan:
- Single M0 read: m0_req, addr 0x0000_1004; slave acks 2 cycles after s_req with rdata 0xA5A5_0001 -> m0_ack pulse 1 cycle later, m0_rdata=0xA5A5_0001, m0_err=0, m1_ack stays 0.
- Simultaneous requests, both held, each master re-requesting right after its ack, zero-wait slave -> grant order M1,M1,M1,M1,M0,M1… (M0 served after 4 debug grants); streak back to 0 after the M0 grant.
- dbg_lock=1 with both masters requesting for 10 transactions -> all 10 grants to M1, m0_ack never pulses; lock released -> M0 granted at the next IDLE.
- No slave ack, TIMEOUT_CYCLES=16 -> s_req high for exactly 16 cycles, then requester ack=1, err=1, rdata=0. s_ack on cycle 16 exactly -> err=0 and rdata captured.
- M1 write (addr 0x0000_2000, wdata 0x0000_00FF, be 0x1) -> s_we=1, s_addr, s_wdata and s_be match for every BUSY cycle; grant_dbg=1 through RESP.
- Assert reset (0) during BUSY -> s_req=0 and all acks 0 immediately (asynchronous). After release, state is IDLE and a new M0 request is granted normally.
